// File: rtl/pong_pkg.sv
// Shared Pong definitions: FSM state codes and winner codes used by the
// match sequencer and the score/HUD display.
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        WIN_NONE  = 2'b00,
        WIN_LEFT  = 2'b01,
        WIN_RIGHT = 2'b10
    } winner_e;

    // Larger of two delays, used to size the shared hold timer.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pong_game_sequencer_button_edge.sv
// Button conditioner: two-flop synchroniser for an asynchronous active-low
// button, followed by a one-tick pulse on each press (1->0 of the
// synchronised level). All flops reset to 0, so a button that is already
// held down when reset ends must be released before it can count as a press.
module button_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic press
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;

    // Next values: shift the button through the synchroniser and remember
    // the last synchronised level.
    always_comb begin
        sync1_d = btn_n;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    // Synchroniser and edge-history registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign press = prev_q & ~sync2_q;

endmodule

// File: rtl/pong_game_sequencer.sv
// Pong match sequencer: holds paddles/ball at their start positions, times
// the serve and post-point pauses, scores misses and declares the winner.
// Every output comes straight from a flop; the paddle/ball resets are
// derived from the next state so they change on the same tick as state.
module pong_game_sequencer
    import pong_pkg::*;
#(
    parameter int WIN_SCORE   = 7,
    parameter int SCORE_W     = 4,
    parameter int SERVE_DELAY = 180,
    parameter int POINT_HOLD  = 120
) (
    input  logic               tick,
    input  logic               reset,
    input  logic               start_n,
    input  logic               miss_left,
    input  logic               miss_right,
    output logic               paddle_reset_n,
    output logic               ball_reset_n,
    output logic [SCORE_W-1:0] score_left,
    output logic [SCORE_W-1:0] score_right,
    output logic [1:0]         winner,
    output logic [2:0]         state
);

    localparam int MAX_D   = max_int(SERVE_DELAY, POINT_HOLD);
    localparam int TIMER_W = (MAX_D > 1) ? $clog2(MAX_D) : 1;

    localparam logic [TIMER_W-1:0] SERVE_LAST = TIMER_W'(SERVE_DELAY - 1);
    localparam logic [TIMER_W-1:0] POINT_LAST = TIMER_W'(POINT_HOLD - 1);
    localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);

    logic press;

    state_e               state_q,  state_d;
    logic [TIMER_W-1:0]   timer_q,  timer_d;
    logic [SCORE_W-1:0]   score_l_q, score_l_d;
    logic [SCORE_W-1:0]   score_r_q, score_r_d;
    winner_e              winner_q, winner_d;
    logic                 paddle_q, paddle_d;
    logic                 ball_q,   ball_d;

    button_edge u_start (
        .clk   (tick),
        .rst   (reset),
        .btn_n (start_n),
        .press (press)
    );

    // Next-state, timer, score and reset-output logic for the match FSM.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        score_l_d = score_l_q;
        score_r_d = score_r_q;
        winner_d  = winner_q;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (press) begin
                    score_l_d = '0;
                    score_r_d = '0;
                    winner_d  = WIN_NONE;
                    timer_d   = '0;
                    state_d   = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (timer_q == SERVE_LAST) begin
                    timer_d = '0;
                    state_d = ST_PLAY;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_PLAY: begin
                if (miss_left && miss_right) begin
                    // Simultaneous misses: replay the point, nobody scores.
                    timer_d = '0;
                    state_d = ST_SERVE;
                end else if (miss_left) begin
                    score_r_d = score_r_q + 1'b1;
                    if (score_r_d == WIN_VAL) begin
                        winner_d = WIN_RIGHT;
                        state_d  = ST_OVER;
                    end else begin
                        timer_d = '0;
                        state_d = ST_POINT;
                    end
                end else if (miss_right) begin
                    score_l_d = score_l_q + 1'b1;
                    if (score_l_d == WIN_VAL) begin
                        winner_d = WIN_LEFT;
                        state_d  = ST_OVER;
                    end else begin
                        timer_d = '0;
                        state_d = ST_POINT;
                    end
                end
            end
            ST_POINT: begin
                if (timer_q == POINT_LAST) begin
                    timer_d = '0;
                    state_d = ST_SERVE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                // Unused codes fall back to IDLE.
                timer_d = '0;
                state_d = ST_IDLE;
            end
        endcase

        paddle_d = (state_d == ST_SERVE) || (state_d == ST_PLAY) || (state_d == ST_POINT);
        ball_d   = (state_d == ST_PLAY);
    end

    // Match state registers.
    always_ff @(posedge tick or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            score_l_q <= '0;
            score_r_q <= '0;
            winner_q  <= WIN_NONE;
            paddle_q  <= 1'b0;
            ball_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            score_l_q <= score_l_d;
            score_r_q <= score_r_d;
            winner_q  <= winner_d;
            paddle_q  <= paddle_d;
            ball_q    <= ball_d;
        end
    end

    assign paddle_reset_n = paddle_q;
    assign ball_reset_n   = ball_q;
    assign score_left     = score_l_q;
    assign score_right    = score_r_q;
    assign winner         = winner_q;
    assign state          = state_q;

endmodule

// File: tb/tb_pong_game_sequencer.sv
// Bench for pong_game_sequencer: a tick-level model of the match rules is
// compared against every output on each falling tick edge, and directed
// scenarios add hand-computed literal expectations.
module tb_pong_game_sequencer;

    localparam int SD  = 4;
    localparam int PH  = 3;
    localparam int WIN = 3;
    localparam int SW  = 4;

    logic          tick;
    logic          reset;
    logic          start_n;
    logic          miss_left;
    logic          miss_right;
    logic          paddle_reset_n;
    logic          ball_reset_n;
    logic [SW-1:0] score_left;
    logic [SW-1:0] score_right;
    logic [1:0]    winner;
    logic [2:0]    state;

    int n_checks = 0;
    int n_err    = 0;
    bit cmp_en   = 0;

    pong_game_sequencer #(
        .WIN_SCORE   (WIN),
        .SCORE_W     (SW),
        .SERVE_DELAY (SD),
        .POINT_HOLD  (PH)
    ) dut (
        .tick           (tick),
        .reset          (reset),
        .start_n        (start_n),
        .miss_left      (miss_left),
        .miss_right     (miss_right),
        .paddle_reset_n (paddle_reset_n),
        .ball_reset_n   (ball_reset_n),
        .score_left     (score_left),
        .score_right    (score_right),
        .winner         (winner),
        .state          (state)
    );

    // clock / reset block
    initial begin
        tick = 1'b0;
        forever #5 tick = ~tick;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // ---------------- behavioural model ----------------
    // m_st: 0 idle, 1 serve, 2 play, 3 point, 4 over.
    // m_left counts ticks remaining in a timed pause.
    int m_st, m_left, m_sl, m_sr, m_win;
    bit h1, h2, h3;   // start_n sampled 1, 2 and 3 ticks ago

    task automatic model_reset();
        m_st = 0; m_left = 0; m_sl = 0; m_sr = 0; m_win = 0;
        h1 = 0; h2 = 0; h3 = 0;
    endtask

    task automatic model_step();
        bit pressed;
        // Falling edge of the button seen through two sync stages.
        pressed = h3 && !h2;
        h3 = h2; h2 = h1; h1 = start_n;
        case (m_st)
            0, 4: if (pressed) begin
                m_sl = 0; m_sr = 0; m_win = 0; m_st = 1; m_left = SD;
            end
            1: begin
                m_left--;
                if (m_left == 0) m_st = 2;
            end
            2: begin
                if (miss_left && miss_right) begin
                    m_st = 1; m_left = SD;
                end else if (miss_left) begin
                    m_sr++;
                    if (m_sr == WIN) begin m_win = 2; m_st = 4; end
                    else begin m_st = 3; m_left = PH; end
                end else if (miss_right) begin
                    m_sl++;
                    if (m_sl == WIN) begin m_win = 1; m_st = 4; end
                    else begin m_st = 3; m_left = PH; end
                end
            end
            3: begin
                m_left--;
                if (m_left == 0) begin m_st = 1; m_left = SD; end
            end
            default: m_st = 0;
        endcase
    endtask

    always @(posedge tick) if (!reset) model_step();

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got %0d exp %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Compare every output against the model on each falling edge.
    always @(negedge tick) begin
        if (cmp_en) begin
            check("m_state",  int'(state),          m_st);
            check("m_paddle", int'(paddle_reset_n), (m_st >= 1 && m_st <= 3) ? 1 : 0);
            check("m_ball",   int'(ball_reset_n),   (m_st == 2) ? 1 : 0);
            check("m_sl",     int'(score_left),     m_sl);
            check("m_sr",     int'(score_right),    m_sr);
            check("m_win",    int'(winner),         m_win);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic ticks(input int n);
        repeat (n) @(negedge tick);
    endtask

    task automatic miss_pulse(input bit l, input bit r);
        miss_left = l; miss_right = r;
        ticks(1);
        miss_left = 0; miss_right = 0;
    endtask

    task automatic check_idle_now(input string tag);
        check({tag, "_state"},  int'(state), 0);
        check({tag, "_padn"},   int'(paddle_reset_n), 0);
        check({tag, "_balln"},  int'(ball_reset_n), 0);
        check({tag, "_sl"},     int'(score_left), 0);
        check({tag, "_sr"},     int'(score_right), 0);
        check({tag, "_win"},    int'(winner), 0);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        reset = 1; start_n = 1; miss_left = 0; miss_right = 0;
        model_reset();
        #1;
        check_idle_now("rst0");
        cmp_en = 1;
        ticks(2);
        reset = 0;
        ticks(3);

        // Start press: SERVE on the 3rd tick after the fall, PLAY 4 ticks later.
        start_n = 0;
        ticks(2);
        check("press_t2_state", int'(state), 0);
        ticks(1);
        check("press_t3_state", int'(state), 1);
        check("press_t3_padn",  int'(paddle_reset_n), 1);
        check("press_t3_balln", int'(ball_reset_n), 0);
        ticks(2);
        start_n = 1;
        ticks(2);
        check("serve_done_state", int'(state), 2);
        check("serve_done_balln", int'(ball_reset_n), 1);

        // Left miss: right scores, POINT for 3 ticks, then SERVE.
        miss_pulse(1, 0);
        check("ml_sr",    int'(score_right), 1);
        check("ml_state", int'(state), 3);
        check("ml_balln", int'(ball_reset_n), 0);
        ticks(2);
        check("point_t2_state", int'(state), 3);
        ticks(1);
        check("point_t3_state", int'(state), 1);
        ticks(4);

        // Both miss together: replay, no score change.
        miss_pulse(1, 1);
        check("both_state", int'(state), 1);
        check("both_sr",    int'(score_right), 1);
        check("both_sl",    int'(score_left), 0);
        ticks(4);

        // Right player reaches WIN_SCORE.
        miss_pulse(1, 0);
        check("ml2_sr", int'(score_right), 2);
        ticks(3 + 4);
        miss_pulse(1, 0);
        check("over_state", int'(state), 4);
        check("over_win",   int'(winner), 2);
        check("over_sr",    int'(score_right), 3);
        check("over_padn",  int'(paddle_reset_n), 0);
        check("over_balln", int'(ball_reset_n), 0);
        miss_pulse(1, 0);
        check("over_ignore_sr", int'(score_right), 3);

        // New match from OVER.
        start_n = 0;
        ticks(3);
        check("rematch_state", int'(state), 1);
        check("rematch_sr",    int'(score_right), 0);
        check("rematch_win",   int'(winner), 0);
        start_n = 1;
        ticks(4);
        check("rematch_play", int'(state), 2);

        // Right miss: left scores.
        miss_pulse(0, 1);
        check("mr_sl",    int'(score_left), 1);
        check("mr_state", int'(state), 3);
        ticks(3 + 4);
        check("mr_back_play", int'(state), 2);

        // Reset mid-PLAY with start held low through release.
        start_n = 0;
        #2;
        reset = 1;
        model_reset();
        #1;
        check_idle_now("rst_mid");
        @(negedge tick);
        reset = 0;
        ticks(6);
        check("held_no_serve", int'(state), 0);
        start_n = 1;
        ticks(3);
        start_n = 0;
        ticks(3);
        check("repress_state", int'(state), 1);
        start_n = 1;
        ticks(2);

        cmp_en = 0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
